// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single unified instruction/data memory port between the
//   multicycle CPU datapath and the external program loader/debug port.
//   Each side issues one transaction at a time with a req/ready handshake.
//   The winner is chosen round-robin on a tie. Its request is registered at
//   grant, the access is sequenced over a fixed read latency, and a one-cycle
//   ready pulse is returned to the owner only.
//
// Ports
//   clk, reset                      clock and synchronous active-high reset
//   cpu_req/we/addr/wdata           CPU transaction request fields
//   cpu_rdata, cpu_ready            CPU read data and completion pulse
//   ld_req/we/addr/wdata            loader transaction request fields
//   ld_rdata, ld_ready              loader read data and completion pulse
//   ld_excl                         loader-exclusive mode (blocks CPU grants)
//   mem_en/we/addr/wdata, mem_rdata memory port
//   busy                            high whenever not idle
//   grant_ld                        current or most recent owner (1 = loader)

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_ready,
  input  logic              ld_excl,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_ld
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t     state;
  logic       last_grant;
  logic [3:0] cnt;
  logic       elig_cpu;
  logic       elig_ld;
  logic       pick_ld;

  // Eligibility and round-robin choice. On a tie the side that did not own
  // the port last wins, so with last_grant = CPU (0) the loader is picked.
  assign elig_cpu = cpu_req & ~ld_excl;
  assign elig_ld  = ld_req;
  assign pick_ld  = elig_ld & (~elig_cpu | ~last_grant);

  // Main sequencer. The request fields are copied straight into the memory
  // port registers at grant, so a requester changing its inputs mid-flight
  // cannot disturb the access. mem_we is only ever high alongside mem_en,
  // which lets ACCESS use it to tell a write from a read. Ready pulses
  // default low and are raised on entry to DONE for the owner alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_ld   <= 1'b0;
      cnt        <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      ld_rdata   <= '0;
      cpu_ready  <= 1'b0;
      ld_ready   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      ld_ready  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (elig_cpu || elig_ld) begin
            grant_ld  <= pick_ld;
            mem_en    <= 1'b1;
            mem_we    <= pick_ld ? ld_we    : cpu_we;
            mem_addr  <= pick_ld ? ld_addr  : cpu_addr;
            mem_wdata <= pick_ld ? ld_wdata : cpu_wdata;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en <= 1'b0;
          if (mem_we) begin
            mem_we <= 1'b0;
            state  <= DONE;
            if (grant_ld) ld_ready  <= 1'b1;
            else          cpu_ready <= 1'b1;
          end else begin
            cnt   <= 4'(MEM_LAT);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            if (grant_ld) begin
              ld_rdata <= mem_rdata;
              ld_ready <= 1'b1;
            end else begin
              cpu_rdata <= mem_rdata;
              cpu_ready <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          last_grant <= grant_ld;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The 4-bit latency counter only covers 1..15.
  lat_range_a: assert property (@(posedge clk) (MEM_LAT >= 1) && (MEM_LAT <= 15));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Instance dut uses MEM_LAT=1 and
//   instance dut3 uses MEM_LAT=3. Both instances share the requester inputs
//   and have separate memory data and outputs. Inputs change and outputs are
//   sampled on the falling edge. Cycle 0 is the cycle in which a request is
//   first seen by the arbiter in IDLE.

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, ld_req, ld_we, ld_excl;
  logic [31:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
  logic [31:0] mem_rdata, mem_rdata3;

  logic [31:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata;
  logic        cpu_ready, ld_ready, mem_en, mem_we, busy, grant_ld;

  logic [31:0] cpu_rdata3, ld_rdata3, mem_addr3, mem_wdata3;
  logic        cpu_ready3, ld_ready3, mem_en3, mem_we3, busy3, grant_ld3;

  int tests = 0;
  int failures = 0;

  // Free-running clock; rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ready(ld_ready), .ld_excl(ld_excl),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_ld(grant_ld)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata3), .cpu_ready(cpu_ready3),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata3), .ld_ready(ld_ready3), .ld_excl(ld_excl),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3), .grant_ld(grant_ld3)
  );

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    cpu_req = 1'b0;
    ld_req  = 1'b0;
    ld_excl = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    next_cycle();
  endtask

  // Reset state of every output, checked while reset is held.
  task automatic test_reset();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    tests++; if (mem_en !== 1'b0)       begin failures++; $display("[TB] FAIL reset_mem_en got %b want 0", mem_en); end
    tests++; if (mem_we !== 1'b0)       begin failures++; $display("[TB] FAIL reset_mem_we got %b want 0", mem_we); end
    tests++; if (cpu_ready !== 1'b0)    begin failures++; $display("[TB] FAIL reset_cpu_ready got %b want 0", cpu_ready); end
    tests++; if (ld_ready !== 1'b0)     begin failures++; $display("[TB] FAIL reset_ld_ready got %b want 0", ld_ready); end
    tests++; if (busy !== 1'b0)         begin failures++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    tests++; if (grant_ld !== 1'b0)     begin failures++; $display("[TB] FAIL reset_grant_ld got %b want 0", grant_ld); end
    tests++; if (mem_addr !== 32'h0)    begin failures++; $display("[TB] FAIL reset_mem_addr got %h want 0", mem_addr); end
    tests++; if (mem_wdata !== 32'h0)   begin failures++; $display("[TB] FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    tests++; if (cpu_rdata !== 32'h0)   begin failures++; $display("[TB] FAIL reset_cpu_rdata got %h want 0", cpu_rdata); end
    tests++; if (ld_rdata !== 32'h0)    begin failures++; $display("[TB] FAIL reset_ld_rdata got %h want 0", ld_rdata); end
    tests++; if (busy3 !== 1'b0)        begin failures++; $display("[TB] FAIL reset_busy3 got %b want 0", busy3); end
    reset = 1'b0;
    next_cycle();
    tests++; if (busy !== 1'b0 || mem_en !== 1'b0) begin failures++; $display("[TB] FAIL idle_after_reset got busy=%b mem_en=%b want 0 0", busy, mem_en); end
  endtask

  // CPU read alone, MEM_LAT=1: mem_en cycle 1, ready and data cycle 3.
  task automatic test_cpu_read();
    mem_rdata = 32'hBAD0BAD0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = 32'h0;
    next_cycle(); // cycle 1
    tests++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rd_c1_en got en=%b we=%b want 1 0", mem_en, mem_we); end
    tests++; if (mem_addr !== 32'h10)  begin failures++; $display("[TB] FAIL rd_c1_addr got %h want 00000010", mem_addr); end
    tests++; if (grant_ld !== 1'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL rd_c1_owner got grant_ld=%b busy=%b want 0 1", grant_ld, busy); end
    next_cycle(); // cycle 2, final WAIT cycle
    mem_rdata = 32'hDEADBEEF;
    tests++; if (mem_en !== 1'b0 || cpu_ready !== 1'b0) begin failures++; $display("[TB] FAIL rd_c2 got en=%b ready=%b want 0 0", mem_en, cpu_ready); end
    next_cycle(); // cycle 3, DONE
    mem_rdata = 32'hBAD1BAD1;
    tests++; if (cpu_ready !== 1'b1) begin failures++; $display("[TB] FAIL rd_c3_ready got %b want 1", cpu_ready); end
    tests++; if (cpu_rdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL rd_c3_data got %h want deadbeef", cpu_rdata); end
    tests++; if (ld_ready !== 1'b0) begin failures++; $display("[TB] FAIL rd_c3_ld_ready got %b want 0", ld_ready); end
    cpu_req = 1'b0;
    next_cycle(); // cycle 4
    tests++; if (cpu_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL rd_c4 got ready=%b busy=%b want 0 0", cpu_ready, busy); end
    tests++; if (cpu_rdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL rd_hold_data got %h want deadbeef", cpu_rdata); end
  endtask

  // Loader write alone: strobe cycle 1, ready cycle 2, idle cycle 3.
  task automatic test_ld_write();
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h4; ld_wdata = 32'h12345678;
    next_cycle(); // cycle 1
    tests++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("[TB] FAIL wr_c1_en got en=%b we=%b want 1 1", mem_en, mem_we); end
    tests++; if (mem_addr !== 32'h4 || mem_wdata !== 32'h12345678) begin failures++; $display("[TB] FAIL wr_c1_fields got addr=%h wdata=%h want 00000004 12345678", mem_addr, mem_wdata); end
    tests++; if (grant_ld !== 1'b1) begin failures++; $display("[TB] FAIL wr_c1_grant got %b want 1", grant_ld); end
    next_cycle(); // cycle 2
    tests++; if (ld_ready !== 1'b1 || cpu_ready !== 1'b0) begin failures++; $display("[TB] FAIL wr_c2_ready got ld=%b cpu=%b want 1 0", ld_ready, cpu_ready); end
    tests++; if (mem_en !== 1'b0) begin failures++; $display("[TB] FAIL wr_c2_en got %b want 0", mem_en); end
    ld_req = 1'b0;
    next_cycle(); // cycle 3
    tests++; if (busy !== 1'b0 || ld_ready !== 1'b0) begin failures++; $display("[TB] FAIL wr_c3 got busy=%b ready=%b want 0 0", busy, ld_ready); end
    tests++; if (ld_rdata !== 32'h0 || cpu_rdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL wr_rdata_kept got ld=%h cpu=%h want 0 deadbeef", ld_rdata, cpu_rdata); end
  endtask

  // Both sides hold write requests after reset: CPU, LD, CPU, LD.
  task automatic test_round_robin();
    logic exp_cpu, exp_ld;
    apply_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'hC0;
    ld_req  = 1'b1; ld_we  = 1'b1; ld_addr  = 32'h200; ld_wdata  = 32'hD0;
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      exp_cpu = (c == 2) || (c == 8);
      exp_ld  = (c == 5) || (c == 11);
      tests++;
      if (cpu_ready !== exp_cpu || ld_ready !== exp_ld) begin
        failures++;
        $display("[TB] FAIL rr_ready_c%0d got cpu=%b ld=%b want %b %b", c, cpu_ready, ld_ready, exp_cpu, exp_ld);
      end
      if (c % 3 == 1) begin
        tests++;
        if (grant_ld !== ((c % 2) == 0) || mem_en !== 1'b1 ||
            mem_addr !== (((c % 2) == 0) ? 32'h200 : 32'h100)) begin
          failures++;
          $display("[TB] FAIL rr_grant_c%0d got grant_ld=%b en=%b addr=%h", c, grant_ld, mem_en, mem_addr);
        end
      end
    end
    cpu_req = 1'b0; ld_req = 1'b0;
    next_cycle();
  endtask

  // Loader-exclusive: four loader writes, no CPU grant, then CPU wins.
  task automatic test_ld_excl();
    int ld_count = 0;
    ld_excl = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h300;
    ld_req  = 1'b1; ld_we  = 1'b1; ld_addr  = 32'h400;
    for (int c = 1; c <= 11; c++) begin
      next_cycle();
      if (ld_ready === 1'b1) ld_count++;
      tests++;
      if (cpu_ready !== 1'b0) begin failures++; $display("[TB] FAIL excl_cpu_ready_c%0d got %b want 0", c, cpu_ready); end
    end
    tests++; if (ld_count != 4) begin failures++; $display("[TB] FAIL excl_ld_count got %0d want 4", ld_count); end
    ld_excl = 1'b0;
    next_cycle(); // cycle 12, IDLE
    next_cycle(); // cycle 13, ACCESS
    tests++; if (grant_ld !== 1'b0 || mem_addr !== 32'h300) begin failures++; $display("[TB] FAIL excl_next_grant got grant_ld=%b addr=%h want 0 00000300", grant_ld, mem_addr); end
    next_cycle(); // cycle 14, DONE
    tests++; if (cpu_ready !== 1'b1 || ld_ready !== 1'b0) begin failures++; $display("[TB] FAIL excl_cpu_done got cpu=%b ld=%b want 1 0", cpu_ready, ld_ready); end
    cpu_req = 1'b0; ld_req = 1'b0;
    next_cycle();
  endtask

  // MEM_LAT=3 CPU read: WAIT cycles 2..4, ready cycle 5, addr held.
  task automatic test_long_latency();
    apply_reset();
    mem_rdata3 = 32'h0BAD0BAD;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    next_cycle(); // cycle 1
    tests++; if (mem_en3 !== 1'b1 || mem_addr3 !== 32'h20) begin failures++; $display("[TB] FAIL lat3_c1 got en=%b addr=%h want 1 00000020", mem_en3, mem_addr3); end
    next_cycle(); // cycle 2
    cpu_addr = 32'h99;
    next_cycle(); // cycle 3
    tests++; if (mem_addr3 !== 32'h20 || cpu_ready3 !== 1'b0) begin failures++; $display("[TB] FAIL lat3_c3 got addr=%h ready=%b want 00000020 0", mem_addr3, cpu_ready3); end
    next_cycle(); // cycle 4, final WAIT cycle
    mem_rdata3 = 32'hA5A5F00D;
    tests++; if (cpu_ready3 !== 1'b0 || busy3 !== 1'b1 || mem_addr3 !== 32'h20) begin failures++; $display("[TB] FAIL lat3_c4 got ready=%b busy=%b addr=%h", cpu_ready3, busy3, mem_addr3); end
    next_cycle(); // cycle 5, DONE
    mem_rdata3 = 32'h0BAD0BAD;
    tests++; if (cpu_ready3 !== 1'b1 || cpu_rdata3 !== 32'hA5A5F00D) begin failures++; $display("[TB] FAIL lat3_c5 got ready=%b data=%h want 1 a5a5f00d", cpu_ready3, cpu_rdata3); end
    cpu_req = 1'b0;
    for (int i = 0; i < 6; i++) next_cycle();
  endtask

  // Reset during a loader read WAIT aborts it; the CPU then wins a tie.
  task automatic test_reset_mid_wait();
    mem_rdata = 32'hCAFEF00D;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h40;
    next_cycle(); // cycle 1
    tests++; if (mem_en !== 1'b1 || grant_ld !== 1'b1) begin failures++; $display("[TB] FAIL rst_c1 got en=%b grant_ld=%b want 1 1", mem_en, grant_ld); end
    next_cycle(); // cycle 2, WAIT
    reset = 1'b1;
    next_cycle(); // cycle 3
    tests++; if (ld_ready !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0) begin failures++; $display("[TB] FAIL rst_c3_ctrl got ready=%b busy=%b en=%b want 0 0 0", ld_ready, busy, mem_en); end
    tests++; if (ld_rdata !== 32'h0 || mem_addr !== 32'h0 || grant_ld !== 1'b0) begin failures++; $display("[TB] FAIL rst_c3_data got rdata=%h addr=%h grant_ld=%b want 0 0 0", ld_rdata, mem_addr, grant_ld); end
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h50; cpu_wdata = 32'h77;
    next_cycle(); // ACCESS of new transaction
    tests++; if (grant_ld !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 32'h50) begin failures++; $display("[TB] FAIL rst_tie_grant got grant_ld=%b en=%b addr=%h want 0 1 00000050", grant_ld, mem_en, mem_addr); end
    next_cycle();
    tests++; if (cpu_ready !== 1'b1 || ld_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_tie_done got cpu=%b ld=%b want 1 0", cpu_ready, ld_ready); end
    cpu_req = 1'b0; ld_req = 1'b0;
    next_cycle();
  endtask

  // Test sequence.
  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0; ld_excl = 1'b0;
    mem_rdata = '0; mem_rdata3 = '0;
    next_cycle();
    test_reset();
    test_cpu_read();
    test_ld_write();
    test_round_robin();
    test_ld_excl();
    test_long_latency();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
